// File: rtl/alu_share_arb_pkg.sv
// Shared ALU definitions: opcode encodings, opcode width and arbiter state encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_share_arb_pkg;

  // Opcode width shared by every ALU client
  localparam int ALU_OP_W = 4;

  // ALU opcodes; any other encoding makes the ALU return zero
  localparam logic [ALU_OP_W-1:0] ALU_OP_ADDU = 4'h0;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SUBU = 4'h1;
  localparam logic [ALU_OP_W-1:0] ALU_OP_ADD  = 4'h2;
  localparam logic [ALU_OP_W-1:0] ALU_OP_AND  = 4'h3;
  localparam logic [ALU_OP_W-1:0] ALU_OP_OR   = 4'h4;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SLT  = 4'h5;
  localparam logic [ALU_OP_W-1:0] ALU_OP_LUI  = 4'h6;

  // Arbiter states: waiting for a request, ALU evaluating, response offered
  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_EXEC = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/alu_share_arb_alu.sv
// Combinational 32-bit ALU with a zero flag that always reflects a-b.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the caller registers the outputs.
module alu
  import alu_share_arb_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]   a_i,
  input  logic [DATA_W-1:0]   b_i,
  input  logic [ALU_OP_W-1:0] op_i,
  output logic [DATA_W-1:0]   c_o,
  output logic                zero_o
);

  logic [DATA_W-1:0] diff;
  logic              lt_signed;

  assign diff      = a_i - b_i;
  assign lt_signed = $signed(a_i) < $signed(b_i);

  // Zero flag is opcode-independent so branch compares can use any opcode
  assign zero_o = (diff == '0);

  // Result select; undefined opcodes deliberately produce zero
  always_comb begin
    c_o = '0;
    case (op_i)
      ALU_OP_ADDU: c_o = a_i + b_i;
      ALU_OP_ADD:  c_o = a_i + b_i;
      ALU_OP_SUBU: c_o = diff;
      ALU_OP_AND:  c_o = a_i & b_i;
      ALU_OP_OR:   c_o = a_i | b_i;
      ALU_OP_SLT:  c_o = {{(DATA_W-1){1'b0}}, lt_signed};
      ALU_OP_LUI:  c_o = b_i << 16;
      default:     c_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_share_arb.sv
// Round-robin share of one ALU between execute (0) and addr-gen/branch (1) requesters.
// Latency: accept in cycle T -> rsp_valid from T+2; one op in flight, max 1 op / 3 cycles.
// Backpressure: req_ready only in IDLE; response held stable until rsp_ready[owner].
module alu_share_arb
  import alu_share_arb_pkg::*;
#(
  parameter int CNT_W  = 16,
  parameter int DATA_W = 32   // must match the ALU; only 32 is supported
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [2*DATA_W-1:0]   req_a,
  input  logic [2*DATA_W-1:0]   req_b,
  input  logic [2*ALU_OP_W-1:0] req_op,
  output logic [1:0]            rsp_valid,
  input  logic [1:0]            rsp_ready,
  output logic [DATA_W-1:0]     rsp_c,
  output logic                  rsp_zero,
  output logic                  busy,
  output logic [CNT_W-1:0]      op_count
);

  arb_state_e state_q, state_d;

  logic                win_id;
  logic                req_acc;
  logic                rsp_hs;

  logic                owner_q;
  logic                last_grant_q;
  logic [DATA_W-1:0]   a_q;
  logic [DATA_W-1:0]   b_q;
  logic [ALU_OP_W-1:0] op_q;
  logic [DATA_W-1:0]   c_q;
  logic                zero_q;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [DATA_W-1:0]   sel_a;
  logic [DATA_W-1:0]   sel_b;
  logic [ALU_OP_W-1:0] sel_op;
  logic [DATA_W-1:0]   alu_c;
  logic                alu_zero;

  // Round-robin winner: a lone requester wins, a tie goes to whoever was not granted last
  always_comb begin
    win_id = 1'b0;
    case (req_valid)
      2'b01:   win_id = 1'b0;
      2'b10:   win_id = 1'b1;
      2'b11:   win_id = ~last_grant_q;
      default: win_id = 1'b0;
    endcase
  end

  assign sel_a  = win_id ? req_a[2*DATA_W-1:DATA_W]     : req_a[DATA_W-1:0];
  assign sel_b  = win_id ? req_b[2*DATA_W-1:DATA_W]     : req_b[DATA_W-1:0];
  assign sel_op = win_id ? req_op[2*ALU_OP_W-1:ALU_OP_W] : req_op[ALU_OP_W-1:0];

  // Next-state and handshake outputs; ready/valid are pure functions of state and inputs
  always_comb begin
    state_d   = state_q;
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    req_acc   = 1'b0;
    rsp_hs    = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (|req_valid) begin
          req_ready[win_id] = 1'b1;
          req_acc           = 1'b1;
          state_d           = ARB_EXEC;
        end
      end
      ARB_EXEC: begin
        state_d = ARB_RESP;
      end
      ARB_RESP: begin
        rsp_valid[owner_q] = 1'b1;
        if (rsp_ready[owner_q]) begin
          rsp_hs  = 1'b1;
          state_d = ARB_IDLE;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // State register; reset drops any in-flight operation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Capture winner's operands and remember ownership for response routing and fairness
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
    end else if (req_acc) begin
      a_q          <= sel_a;
      b_q          <= sel_b;
      op_q         <= sel_op;
      owner_q      <= win_id;
      last_grant_q <= win_id;
    end
  end

  alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .a_i    (a_q),
    .b_i    (b_q),
    .op_i   (op_q),
    .c_o    (alu_c),
    .zero_o (alu_zero)
  );

  // Result register loads only at the end of EXEC, so it stays stable through RESP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_q    <= '0;
      zero_q <= 1'b0;
    end else if (state_q == ARB_EXEC) begin
      c_q    <= alu_c;
      zero_q <= alu_zero;
    end
  end

  // Completed-operation count, saturating at all-ones
  always_comb begin
    cnt_d = cnt_q;
    if (rsp_hs && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign rsp_c    = c_q;
  assign rsp_zero = zero_q;
  assign busy     = (state_q != ARB_IDLE);
  assign op_count = cnt_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// Bench for alu_share_arb: directed scenarios plus randomized traffic against a reference model.
// Latency: checks response two cycles after accept.
// Backpressure: exercises held rsp_ready and non-owner ready.
module tb_alu_share_arb;
  import alu_share_arb_pkg::*;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [63:0]       req_a;
  logic [63:0]       req_b;
  logic [7:0]        req_op;
  logic [1:0]        rsp_valid;
  logic [1:0]        rsp_ready;
  logic [31:0]       rsp_c;
  logic              rsp_zero;
  logic              busy;
  logic [CNT_W-1:0]  op_count;

  int checks = 0;
  int errors = 0;
  int ref_last;    // requester granted most recently
  int ref_count;   // completed handshakes, saturating

  alu_share_arb #(.CNT_W(CNT_W), .DATA_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_c     (rsp_c),
    .rsp_zero  (rsp_zero),
    .busy      (busy),
    .op_count  (op_count)
  );

  always #5 clk = ~clk;

  // Reference ALU computed from the opcode meanings
  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      ALU_OP_ADDU: return a + b;
      ALU_OP_ADD:  return a + b;
      ALU_OP_SUBU: return a - b;
      ALU_OP_AND:  return a & b;
      ALU_OP_OR:   return a | b;
      ALU_OP_SLT:  return (sa < sb) ? 32'd1 : 32'd0;
      ALU_OP_LUI:  return (b % 32'd65536) * 32'd65536;
      default:     return 32'd0;
    endcase
  endfunction

  function automatic int ref_winner(input logic [1:0] v);
    if (v == 2'b11) return 1 - ref_last;
    if (v[1]) return 1;
    return 0;
  endfunction

  function automatic void ref_done();
    if (ref_count < CNT_MAX) ref_count++;
  endfunction

  task automatic present(input int r, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    req_valid[r]      = 1'b1;
    req_a[r*32 +: 32] = a;
    req_b[r*32 +: 32] = b;
    req_op[r*4 +: 4]  = op;
  endtask

  // Runs one operation to completion; starts and ends on a falling edge
  task automatic serve(output int who, output logic [1:0] vld, output logic [31:0] c,
                       output logic z, output int lat);
    int n;
    who = -1; lat = -1; vld = 2'b00; c = '0; z = 1'b0;
    n = 0;
    #1;
    while (req_ready == 2'b00 && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (req_ready == 2'b00) return;
    who = req_ready[1] ? 1 : 0;
    @(posedge clk);
    @(negedge clk);
    req_valid[who] = 1'b0;
    lat = 1;
    while (rsp_valid == 2'b00 && lat < 10) begin
      @(negedge clk); lat++;
    end
    vld = rsp_valid; c = rsp_c; z = rsp_zero;
    if (rsp_valid == 2'b00) return;
    rsp_ready = 2'b01 << who;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 2'b00;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; req_op = '0; rsp_ready = '0;
    ref_last = 1; ref_count = 0;
    repeat (3) @(negedge clk);
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 00", rsp_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (op_count !== '0) begin errors++; $display("FAIL reset_op_count: got %0d expected 0", op_count); end
    checks++; if (rsp_c !== 32'd0 || rsp_zero !== 1'b0) begin errors++; $display("FAIL reset_result: got %h/%b expected 0/0", rsp_c, rsp_zero); end
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready: got %b expected 00", req_ready); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    int who, lat; logic [1:0] vld; logic [31:0] c; logic z;
    present(0, ALU_OP_ADDU, 32'd5, 32'd7);
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL single_ready: got %b expected 01", req_ready); end
    serve(who, vld, c, z, lat);
    ref_last = 0; ref_done();
    checks++; if (who !== 0) begin errors++; $display("FAIL single_winner: got %0d expected 0", who); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL single_latency: got %0d expected 2", lat); end
    checks++; if (vld !== 2'b01) begin errors++; $display("FAIL single_rsp_valid: got %b expected 01", vld); end
    checks++; if (c !== 32'd12 || z !== 1'b0) begin errors++; $display("FAIL single_result: got %h/%b expected 0000000c/0", c, z); end
    checks++; if (op_count !== ref_count) begin errors++; $display("FAIL single_count: got %0d expected %0d", op_count, ref_count); end
  endtask

  task automatic test_contention();
    int who, lat, exp; logic [1:0] vld; logic [31:0] c; logic z;
    logic [31:0] res [2];
    logic        zr  [2];
    res[0] = 32'd0;  zr[0] = 1'b1;   // SUBU 9-9
    res[1] = 32'hFF; zr[1] = 1'b0;   // OR F0|0F
    present(0, ALU_OP_SUBU, 32'd9, 32'd9);
    present(1, ALU_OP_OR, 32'hF0, 32'h0F);
    for (int k = 0; k < 4; k++) begin
      exp = ref_winner(req_valid);
      serve(who, vld, c, z, lat);
      ref_last = exp; ref_done();
      checks++; if (who !== exp) begin errors++; $display("FAIL contend_winner[%0d]: got %0d expected %0d", k, who, exp); end
      checks++; if (vld !== (2'b01 << exp)) begin errors++; $display("FAIL contend_rsp_valid[%0d]: got %b expected %b", k, vld, 2'b01 << exp); end
      checks++; if (c !== res[exp] || z !== zr[exp]) begin errors++; $display("FAIL contend_result[%0d]: got %h/%b expected %h/%b", k, c, z, res[exp], zr[exp]); end
      // keep the served requester coming back so the pair keeps contending
      if (k < 2 && exp >= 0) begin
        if (exp == 0) present(0, ALU_OP_SUBU, 32'd9, 32'd9);
        else present(1, ALU_OP_OR, 32'hF0, 32'h0F);
      end
    end
    checks++; if (op_count !== ref_count) begin errors++; $display("FAIL contend_count: got %0d expected %0d", op_count, ref_count); end
  endtask

  task automatic test_backpressure();
    int who, lat, exp; logic [1:0] vld; logic [31:0] c; logic z;
    present(1, ALU_OP_SLT, 32'hFFFF_FFFF, 32'd1);
    exp = ref_winner(req_valid);
    #1;
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL bp_accept: got %b expected 10", req_ready); end
    @(posedge clk);
    @(negedge clk);
    req_valid[1] = 1'b0;
    ref_last = exp;
    present(0, ALU_OP_ADDU, 32'd2, 32'd3);
    rsp_ready = 2'b01;   // non-owner ready must not complete the response
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if (rsp_valid !== 2'b10 || rsp_c !== 32'd1 || rsp_zero !== 1'b0 || req_ready !== 2'b00 || busy !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got vld=%b c=%h z=%b rdy=%b busy=%b expected vld=10 c=00000001 z=0 rdy=00 busy=1",
                 k, rsp_valid, rsp_c, rsp_zero, req_ready, busy);
      end
      @(negedge clk);
    end
    rsp_ready = 2'b10;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 2'b00;
    ref_done();
    checks++; if (op_count !== ref_count || busy !== 1'b0) begin errors++; $display("FAIL bp_complete: got count=%0d busy=%b expected %0d/0", op_count, busy, ref_count); end
    exp = ref_winner(req_valid);
    serve(who, vld, c, z, lat);
    ref_last = exp; ref_done();
    checks++; if (who !== 0 || c !== 32'd5) begin errors++; $display("FAIL bp_next: got who=%0d c=%h expected 0/00000005", who, c); end
  endtask

  task automatic test_reset_mid();
    int who, lat, exp; logic [1:0] vld; logic [31:0] c; logic z;
    bit   seen;
    present(0, ALU_OP_ADDU, 32'd1, 32'd2);
    @(posedge clk);
    #2;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before: got %b expected 1", busy); end
    rst_n = 1'b0;
    #1;
    checks++; if (rsp_valid !== 2'b00 || busy !== 1'b0 || op_count !== '0) begin errors++; $display("FAIL mid_async: got vld=%b busy=%b count=%0d expected 00/0/0", rsp_valid, busy, op_count); end
    req_valid = 2'b00;
    ref_last = 1; ref_count = 0;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid !== 2'b00) seen = 1'b1;
    end
    checks++; if (seen) begin errors++; $display("FAIL mid_no_response: got response after reset expected none"); end
    present(0, ALU_OP_AND, 32'hF0F0, 32'hFF00);
    present(1, ALU_OP_ADD, 32'd1, 32'd1);
    exp = ref_winner(req_valid);
    serve(who, vld, c, z, lat);
    ref_last = exp; ref_done();
    checks++; if (who !== 0 || c !== 32'hF000) begin errors++; $display("FAIL mid_first_grant: got who=%0d c=%h expected 0/0000f000", who, c); end
    exp = ref_winner(req_valid);
    serve(who, vld, c, z, lat);
    ref_last = exp; ref_done();
    checks++; if (who !== 1 || c !== 32'd2) begin errors++; $display("FAIL mid_second_grant: got who=%0d c=%h expected 1/00000002", who, c); end
  endtask

  task automatic test_opcodes();
    int who, lat; logic [1:0] vld; logic [31:0] c; logic z;
    present(1, ALU_OP_LUI, 32'd0, 32'h1234);
    serve(who, vld, c, z, lat);
    ref_last = 1; ref_done();
    checks++; if (c !== 32'h1234_0000) begin errors++; $display("FAIL lui: got %h expected 12340000", c); end
    present(0, 4'hF, 32'd3, 32'd3);
    serve(who, vld, c, z, lat);
    ref_last = 0; ref_done();
    checks++; if (c !== 32'd0 || z !== 1'b1) begin errors++; $display("FAIL undef_op: got %h/%b expected 00000000/1", c, z); end
  endtask

  task automatic test_random();
    int who, lat, exp; logic [1:0] vld; logic [31:0] c; logic z;
    logic [31:0] pa [2];
    logic [31:0] pb [2];
    logic [3:0]  po [2];
    for (int k = 0; k < 40; k++) begin
      for (int r = 0; r < 2; r++) begin
        if (!req_valid[r] && ($urandom_range(0, 1) == 1 || (r == 1 && req_valid == 2'b00))) begin
          po[r] = 4'($urandom_range(0, 15));
          pa[r] = $urandom;
          pb[r] = ($urandom_range(0, 3) == 0) ? pa[r] : $urandom;
          present(r, po[r], pa[r], pb[r]);
        end
      end
      exp = ref_winner(req_valid);
      serve(who, vld, c, z, lat);
      ref_last = exp; ref_done();
      checks++; if (who !== exp) begin errors++; $display("FAIL rand_winner[%0d]: got %0d expected %0d", k, who, exp); end
      checks++; if (lat !== 2 || vld !== (2'b01 << exp)) begin errors++; $display("FAIL rand_rsp[%0d]: got lat=%0d vld=%b expected 2/%b", k, lat, vld, 2'b01 << exp); end
      checks++;
      if (c !== ref_alu(po[exp], pa[exp], pb[exp]) || z !== (pa[exp] == pb[exp])) begin
        errors++;
        $display("FAIL rand_result[%0d]: got %h/%b expected %h/%b", k, c, z, ref_alu(po[exp], pa[exp], pb[exp]), pa[exp] == pb[exp]);
      end
      checks++; if (op_count !== ref_count) begin errors++; $display("FAIL rand_count[%0d]: got %0d expected %0d", k, op_count, ref_count); end
    end
    // drain any leftover request
    if (req_valid != 2'b00) begin
      exp = ref_winner(req_valid);
      serve(who, vld, c, z, lat);
      ref_last = exp; ref_done();
    end
  endtask

  task automatic test_saturate();
    int who, lat; logic [1:0] vld; logic [31:0] c; logic z;
    for (int k = 0; k < CNT_MAX + 4; k++) begin
      present(0, ALU_OP_ADDU, k, 32'd1);
      serve(who, vld, c, z, lat);
      ref_last = 0; ref_done();
      checks++; if (op_count !== ref_count) begin errors++; $display("FAIL sat_count[%0d]: got %0d expected %0d", k, op_count, ref_count); end
    end
    checks++; if (op_count !== CNT_MAX) begin errors++; $display("FAIL sat_hold: got %0d expected %0d", op_count, CNT_MAX); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_reset_mid();
    test_opcodes();
    test_random();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at time limit, expected completion");
    $fatal(1);
  end

endmodule
